// File: rtl/core_pkg.sv
// Shared definitions for multicycle_core: opcodes, funct codes, ALU ops,
// FSM states and the instruction decoder.
package core_pkg;

  localparam logic [6:0]  OP_R       = 7'h33;
  localparam logic [6:0]  OP_I       = 7'h13;
  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic    legal;
    logic    ecall;
    logic    use_imm;
    alu_op_t op;
  } decode_t;

  // Maps funct3 to an ALU op; alt selects SUB/SRA where the encoding allows it.
  function automatic alu_op_t alu_op_of(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Classifies an instruction word: legal ALU op, ECALL, or illegal.
  function automatic decode_t decode(input logic [31:0] ir);
    decode_t    d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_ok;
    f3    = ir[14:12];
    f7    = ir[31:25];
    f7_ok = (f7 == F7_BASE) || (f7 == F7_ALT);
    d     = '{legal: 1'b0, ecall: 1'b0, use_imm: 1'b0, op: ALU_ADD};
    if (ir == ECALL_WORD) begin
      d.ecall = 1'b1;
    end else if (ir[6:0] == OP_R) begin
      // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
      d.legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == F3_ADD || f3 == F3_SR));
      d.op    = alu_op_of(f3, f7[5]);
    end else if (ir[6:0] == OP_I) begin
      d.use_imm = 1'b1;
      // Immediate shifts reuse imm[11:5] as funct7; other I-ops have no funct7.
      d.legal   = (f3 == F3_SLL || f3 == F3_SR) ? f7_ok : 1'b1;
      d.op      = alu_op_of(f3, (f3 == F3_SR) && f7[5]);
    end
    return d;
  endfunction

endpackage

// File: rtl/regfile_p.sv
// Register file: two combinational read ports, one synchronous write port,
// x0 hard-wired to zero, asynchronous reset of every entry.
module regfile_p #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  output logic [XLEN-1:0]          rdata1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [XLEN-1:0]          rdata2
);

  logic [XLEN-1:0] regs [NREGS];

  // Write port; reset clears the architectural state.
  // NOTE: storage arrays are usually left unreset, but this is a flop array
  // whose contents are architectural, so every entry is cleared on reset.
  // NOTE: clocked state uses <= so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset ALU core: FETCH/DECODE/EXEC/WB, one instruction
// retired every 4 cycles, halts on ECALL, illegal instruction or stop.
module multicycle_core #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int IMEM_AW = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               zf,
  output logic [CNT_W-1:0]   retired,
  output logic               wb_valid,
  output logic [4:0]         wb_addr,
  output logic [XLEN-1:0]    wb_data
);
  import core_pkg::*;

  localparam int RAW = $clog2(NREGS);
  localparam int SHW = $clog2(XLEN);

  state_t             state;
  logic [IMEM_AW-1:0] pc;
  logic [31:0]        ir;
  logic [XLEN-1:0]    a_q, b_q, r_q;
  alu_op_t            op_q;
  logic [4:0]         wb_rd_q;
  logic               busy_q, done_q, err_q, zf_q;
  logic [CNT_W-1:0]   retired_q;

  decode_t            dec;
  logic [XLEN-1:0]    rs1_data, rs2_data, imm_sext, alu_res;
  logic [SHW-1:0]     shamt;

  assign dec      = decode(ir);
  assign imm_sext = XLEN'($signed(ir[31:20]));
  assign shamt    = b_q[SHW-1:0];

  regfile_p #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (state == S_WB),
    .waddr  (wb_rd_q[RAW-1:0]),
    .wdata  (r_q),
    .raddr1 (ir[15 +: RAW]),
    .rdata1 (rs1_data),
    .raddr2 (ir[20 +: RAW]),
    .rdata2 (rs2_data)
  );

  // ALU on the operands latched in DECODE.
  always_comb begin
    // NOTE: default assignment first so no op leaves alu_res unassigned (latch).
    alu_res = a_q + b_q;
    case (op_q)
      ALU_SUB:  alu_res = a_q - b_q;
      ALU_SLL:  alu_res = a_q << shamt;
      ALU_SLT:  alu_res = XLEN'($signed(a_q) < $signed(b_q));
      ALU_SLTU: alu_res = XLEN'(a_q < b_q);
      ALU_XOR:  alu_res = a_q ^ b_q;
      ALU_SRL:  alu_res = a_q >> shamt;
      ALU_SRA:  alu_res = $signed(a_q) >>> shamt;
      ALU_OR:   alu_res = a_q | b_q;
      ALU_AND:  alu_res = a_q & b_q;
      default:  alu_res = a_q + b_q;
    endcase
  end

  // Control FSM with its datapath registers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      op_q      <= ALU_ADD;
      wb_rd_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      zf_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state  <= S_FETCH;
            pc     <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= imem_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (!dec.legal) begin
            // ECALL or illegal: stop here, PC stays on this word.
            state  <= S_HALT;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            if (!dec.ecall) err_q <= 1'b1;
          end else begin
            a_q   <= rs1_data;
            b_q   <= dec.use_imm ? imm_sext : rs2_data;
            op_q  <= dec.op;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_q     <= alu_res;
          zf_q    <= (alu_res == '0);
          wb_rd_q <= ir[11:7];
          state   <= S_WB;
        end
        S_WB: begin
          pc        <= pc + 1'b1;
          retired_q <= retired_q + 1'b1;
          if (stop) begin
            state  <= S_HALT;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = pc;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign zf        = zf_q;
  assign retired   = retired_q;
  assign wb_valid  = (state == S_WB) && (wb_rd_q[RAW-1:0] != '0);
  assign wb_addr   = wb_rd_q;
  assign wb_data   = r_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: directed programs plus randomized programs
// checked against an instruction-level reference model; a second instance
// with a 4-word instruction memory exercises PC wrap.
module tb_multicycle_core;

  localparam int CNT_W = 16;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [1:0] K_OK = 2'd0, K_ECALL = 2'd1, K_ILL = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] val;
  } res_t;

  logic clk, rst, start, stop;
  logic [4:0]       imem_addr;
  logic [31:0]      imem_data;
  logic             busy, done, err, zf, wb_valid;
  logic [CNT_W-1:0] retired;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;

  logic w_start, w_stop;
  logic [1:0]       w_imem_addr;
  logic [31:0]      w_imem_data;
  logic             w_busy, w_done, w_err, w_zf, w_wb_valid;
  logic [CNT_W-1:0] w_retired;
  logic [4:0]       w_wb_addr;
  logic [31:0]      w_wb_data;

  logic [31:0] imem   [32];
  logic [31:0] w_imem [4];
  logic [31:0] mregs  [32];
  logic [CNT_W-1:0] ret_m;
  logic [31:0] obs       [32];
  logic        obs_zf    [32];
  logic        obs_valid [32];

  int n_tests = 0;
  int n_fail  = 0;

  assign imem_data   = imem[imem_addr];
  assign w_imem_data = w_imem[w_imem_addr];

  multicycle_core #(.XLEN(32), .NREGS(32), .IMEM_AW(5), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .busy(busy), .done(done), .err(err), .zf(zf), .retired(retired),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  multicycle_core #(.XLEN(32), .NREGS(32), .IMEM_AW(2), .CNT_W(CNT_W)) u_wrap (
    .clk(clk), .rst(rst), .start(w_start), .stop(w_stop),
    .imem_addr(w_imem_addr), .imem_data(w_imem_data),
    .busy(w_busy), .done(w_done), .err(w_err), .zf(w_zf), .retired(w_retired),
    .wb_valid(w_wb_valid), .wb_addr(w_wb_addr), .wb_data(w_wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  // Instruction semantics by mnemonic, in plain 32-bit arithmetic.
  function automatic logic [31:0] alu_ref(input string op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    if (op == "add")  return a + b;
    if (op == "sub")  return a - b;
    if (op == "sll")  return a << sh;
    if (op == "slt")  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    if (op == "sltu") return (a < b) ? 32'd1 : 32'd0;
    if (op == "xor")  return a ^ b;
    if (op == "srl")  return a >> sh;
    if (op == "sra")  return $signed(a) >>> sh;
    if (op == "or")   return a | b;
    return a & b;
  endfunction

  // Reference model: outcome of one instruction against the model registers.
  function automatic res_t model_step(input logic [31:0] w);
    res_t        r;
    logic [31:0] a, b;
    string       name;
    r.kind = K_OK;
    r.rd   = w[11:7];
    r.val  = '0;
    name   = "";
    a = mregs[w[19:15]];
    b = (w[6:0] == 7'h33) ? mregs[w[24:20]] : {{20{w[31]}}, w[31:20]};
    if (w == ECALL) begin
      r.kind = K_ECALL;
    end else if (w[6:0] == 7'h33) begin
      case ({w[31:25], w[14:12]})
        {7'h00, 3'd0}: name = "add";
        {7'h20, 3'd0}: name = "sub";
        {7'h00, 3'd1}: name = "sll";
        {7'h00, 3'd2}: name = "slt";
        {7'h00, 3'd3}: name = "sltu";
        {7'h00, 3'd4}: name = "xor";
        {7'h00, 3'd5}: name = "srl";
        {7'h20, 3'd5}: name = "sra";
        {7'h00, 3'd6}: name = "or";
        {7'h00, 3'd7}: name = "and";
        default:       name = "";
      endcase
    end else if (w[6:0] == 7'h13) begin
      case (w[14:12])
        3'd0: name = "add";
        3'd2: name = "slt";
        3'd3: name = "sltu";
        3'd4: name = "xor";
        3'd6: name = "or";
        3'd7: name = "and";
        3'd1: name = (w[31:25] == 7'h00 || w[31:25] == 7'h20) ? "sll" : "";
        default: name = (w[31:25] == 7'h00) ? "srl" : (w[31:25] == 7'h20) ? "sra" : "";
      endcase
    end
    if (r.kind == K_OK) begin
      if (name == "") r.kind = K_ILL;
      else r.val = alu_ref(name, a, b);
    end
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_zf"}, zf, 0);
    check({tag, "_retired"}, retired, 0);
    check({tag, "_wb_valid"}, wb_valid, 0);
    check({tag, "_wb_addr"}, wb_addr, 0);
    check({tag, "_wb_data"}, wb_data, 0);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = ECALL;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Starts the core and follows it one instruction (4 cycles) at a time,
  // comparing every observable against the model. stop_at = index of the
  // instruction during whose EXEC stop is raised (-1 for none).
  task automatic run_prog(input int stop_at);
    res_t        r;
    logic [4:0]  pc_m;
    pc_m = '0;
    pulse_start();
    for (int k = 0; k < 32; k++) begin
      check("fetch_pc", imem_addr, pc_m);
      check("fetch_busy", busy, 1);
      check("fetch_err", err, 0);
      check("fetch_retired", retired, ret_m);
      r = model_step(imem[pc_m]);
      @(negedge clk);
      if (r.kind != K_OK) begin
        @(negedge clk);
        check("halt_done", done, 1);
        check("halt_busy", busy, 0);
        check("halt_err", err, r.kind == K_ILL);
        check("halt_retired", retired, ret_m);
        check("halt_pc", imem_addr, pc_m);
        check("halt_wb_valid", wb_valid, 0);
        return;
      end
      @(negedge clk);
      if (k == stop_at) stop = 1'b1;
      @(negedge clk);
      check("wb_valid", wb_valid, r.rd != 0);
      if (r.rd != 0) begin
        check("wb_addr", wb_addr, r.rd);
        check("wb_data", wb_data, r.val);
      end
      check("wb_zf", zf, r.val == 0);
      check("wb_done", done, 0);
      obs[k]       = wb_data;
      obs_zf[k]    = zf;
      obs_valid[k] = wb_valid;
      if (r.rd != 0) mregs[r.rd] = r.val;
      pc_m++;
      ret_m++;
      @(negedge clk);
      if (k == stop_at) begin
        stop = 1'b0;
        check("stop_done", done, 1);
        check("stop_busy", busy, 0);
        check("stop_pc", imem_addr, pc_m);
        check("stop_retired", retired, ret_m);
        return;
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    int sel;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom);
    sel = $urandom_range(0, 9);
    if (sel < 3) return enc_i(12'($urandom), rs1, 3'd0, rd);
    if (sel < 6)
      return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                   rs2, rs1, f3, rd);
    if (f3 == 3'd1 || f3 == 3'd5)
      return enc_i({($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, 5'($urandom)}, rs1, f3, rd);
    return enc_i(12'($urandom), rs1, f3, rd);
  endfunction

  function automatic logic [31:0] rand_illegal();
    case ($urandom_range(0, 2))
      0:       return enc_r(7'h01, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
      1:       return {25'($urandom), 7'h03};
      default: return enc_i({7'h10, 5'($urandom)}, 5'($urandom), 3'd5, 5'($urandom));
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; w_start = 1'b0; w_stop = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    for (int i = 0; i < 4; i++) w_imem[i] = enc_i(12'd1, 5'd1, 3'd0, 5'd1);
    ret_m = '0;
    clear_imem();
    #1;
    check_reset_outputs("rst_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_idle");

    // Basic program: 5 + (-3) = 2, ECALL halts after three retirements.
    clear_imem();
    imem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
    imem[1] = enc_i(12'hFFD, 5'd0, 3'd0, 5'd2);
    imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    run_prog(-1);
    check("plan_x3", obs[2], 32'd2);
    check("plan_retired", retired, 3);
    check("plan_err", err, 0);

    // SUB/SLT/SLTU/SRAI and x0 writes; registers persist across start.
    clear_imem();
    imem[0] = enc_r(7'h20, 5'd1, 5'd1, 3'd0, 5'd4);
    imem[1] = enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5);
    imem[2] = enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd5);
    imem[3] = enc_i(12'd1, 5'd0, 3'd0, 5'd6);
    imem[4] = enc_i({7'h00, 5'd31}, 5'd6, 3'd1, 5'd6);
    imem[5] = enc_i({7'h20, 5'd4}, 5'd6, 3'd5, 5'd7);
    imem[6] = enc_i(12'd7, 5'd0, 3'd0, 5'd0);
    imem[7] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd8);
    run_prog(-1);
    check("sub_data", obs[0], 32'd0);
    check("sub_zf", obs_zf[0], 1);
    check("slt", obs[1], 32'd1);
    check("sltu", obs[2], 32'd0);
    check("slli", obs[4], 32'h8000_0000);
    check("srai", obs[5], 32'hF800_0000);
    check("x0_valid", obs_valid[6], 0);
    check("x0_reads_0", obs[7], 32'd0);
    check("b_retired", retired, 11);

    // Illegal word halts with err, PC on the offending word.
    clear_imem();
    imem[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd9);
    imem[1] = 32'h0000_007F;
    run_prog(-1);
    check("ill_err", err, 1);
    check("ill_pc", imem_addr, 1);
    check("ill_retired", retired, 12);

    // Restart clears err and refetches from 0; stop raised in EXEC of the 2nd.
    clear_imem();
    imem[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd10);
    for (int i = 1; i < 4; i++) imem[i] = enc_i(12'd1, 5'd10, 3'd0, 5'd10);
    run_prog(1);
    check("stop_x10", obs[1], 32'd2);
    check("stop_pc_const", imem_addr, 2);
    check("stop_retired_const", retired, 14);

    // Reset asserted during EXEC clears everything immediately.
    clear_imem();
    imem[0] = enc_i(12'd9, 5'd0, 3'd0, 5'd1);
    pulse_start();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_exec");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    ret_m = '0;
    clear_imem();
    imem[0] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd7);
    run_prog(-1);
    check("post_rst_regs", obs[0], 32'd0);
    check("post_rst_retired", retired, 1);

    // Randomized programs, some ending in an illegal word.
    for (int p = 0; p < 10; p++) begin
      int n;
      clear_imem();
      n = $urandom_range(8, 28);
      for (int i = 0; i < n; i++) imem[i] = rand_instr();
      if (p % 3 == 2) imem[n] = rand_illegal();
      run_prog(-1);
    end

    // 4-word memory, no ECALL: PC wraps 3 -> 0 and x1 keeps counting.
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("wrap_pc", w_imem_addr, k % 4);
      check("wrap_retired", w_retired, k);
      check("wrap_busy", w_busy, 1);
      repeat (2) @(negedge clk);
      if (k == 5) w_stop = 1'b1;
      @(negedge clk);
      check("wrap_wb_valid", w_wb_valid, 1);
      check("wrap_wb_addr", w_wb_addr, 1);
      check("wrap_wb_data", w_wb_data, k + 1);
      check("wrap_zf", w_zf, 0);
      check("wrap_done", w_done, 0);
      @(negedge clk);
    end
    w_stop = 1'b0;
    check("wrap_halt_done", w_done, 1);
    check("wrap_halt_busy", w_busy, 0);
    check("wrap_halt_err", w_err, 0);
    check("wrap_halt_retired", w_retired, 6);
    check("wrap_halt_pc", w_imem_addr, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multicycle successor to the single-cycle instruction/register-file/ALU driver. It fetches words from an external instruction memory through its own program counter and executes RV32I-subset ALU instructions through a DECODE/EXEC/WB state machine. It retires one instruction every 4 cycles and writes back into an internal register file. It reports halt, error, retired-instruction count and last write for bench and top-level observation.

## Interface
- `XLEN`, 32: datapath width; legal values are 32 or 64.
- `NREGS`, 32: register count, power of 2, ≤ 32. rd/rs indices are taken modulo NREGS.
- `IMEM_AW`, 5: instruction memory word-address width. The PC wraps at 2^IMEM_AW.
- `CNT_W`, 16: retired-counter width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `start`  in  1  one-cycle pulse. Honoured only in IDLE or HALT.
- `stop`  in  1  level. Requests a halt at the next WB.
- `imem_addr`  out  IMEM_AW  word address; equals the PC.
- `imem_data`  in  32  instruction word, combinationally valid in the same cycle as `imem_addr`.
- `busy`  out  1  high in FETCH, DECODE, EXEC and WB.
- `done`  out  1  high in HALT.
- `err`  out  1  sticky illegal-instruction flag.
- `zf`  out  1  zero flag of the last EXEC result.
- `retired`  out  CNT_W  count of instructions written back.
- `wb_valid`  out  1  one-cycle strobe in WB when rd≠0.
- `wb_addr`  out  5  rd of the current write.
- `wb_data`  out  XLEN  data of the current write.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- Transitions:
  - IDLE –start→ FETCH → DECODE → EXEC → WB.
  - WB → FETCH, or WB → HALT when `stop`=1.
  - DECODE → HALT on ECALL (0x00000073) or on an illegal instruction.
  - HALT –start→ FETCH.
- FETCH: IR ← imem_data at imem_addr=PC.
- DECODE: A ← x[rs1], B ← x[rs2] or sign-extended imm[11:0]. The ALU op is selected from opcode/funct3/funct7.
- Supported instructions:
  - R-type (0x33): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - I-type (0x13): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Anything else is illegal: `err`←1, next state HALT, no write, PC unchanged.
- EXEC: R ← ALU(A,B); zf ← (R==0).
- Arithmetic is modulo 2^XLEN. Shift amount is B[log2(XLEN)-1:0]. SLT is signed, SLTU unsigned, result zero-extended.
- SUB/SRA/SRAI are selected by funct7[5]. For I-type shifts, a funct7 other than 0x00/0x20 is illegal.
- WB: x[rd] ← R unless rd==0; PC ← PC+1 mod 2^IMEM_AW; `retired`++ (wraps); `wb_valid`=(rd≠0).
- x0 always reads 0.
- `start` from HALT sets PC←0 and clears `err`. The register file and `retired` are preserved.
- `start` outside IDLE/HALT is ignored.
- `stop` is sampled only in WB. The instruction in WB still retires.
- Reset mid-instruction aborts it:
  - state←IDLE, PC←0, IR←0.
  - All regs←0.
  - Outputs take reset values.

## Timing
- Reset values: imem_addr=0, busy=0, done=0, err=0, zf=0, retired=0, wb_valid=0, wb_addr=0, wb_data=0.
- Each instruction occupies exactly 4 cycles (FETCH..WB). `retired` and the register file update on the clock edge ending WB.
- A read-after-write in the next instruction sees the new value: DECODE of instruction n+1 is 2 cycles after WB of n, so no forwarding is needed.
- `start` at edge t → state FETCH at t+1 → `busy`=1 from t+1.
- ECALL/illegal: `done`=1 on the cycle after DECODE. The ECALL itself does not count in `retired`.
- `wb_*` outputs are combinational from WB-state registers, valid only while `wb_valid`=1. Otherwise they hold their last values.
- PC wrap: from 2^IMEM_AW−1 the PC goes to 0 with no halt.

## Structure
- Shared package `core_pkg` holds:
  - opcode constants (OP_R=7'h33, OP_I=7'h13, ECALL word);
  - funct3 codes;
  - an ALU-op enum;
  - the FSM state enum.
- Sub-module `regfile_p` (params XLEN, NREGS): asynchronous reset, 2 combinational read ports, 1 synchronous write port, x0 hard-wired to 0.
- ALU and decode are inline combinational logic in `multicycle_core`.

## Test plan
- Reset, then start; imem = {ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; ECALL}:
  - x3=2;
  - `retired`=3;
  - `done` asserted 15 cycles after start;
  - `err`=0.
- SUB x4,x1,x1 → wb_data=0, zf=1.
- SLT x5,x2,x1 → 1; SLTU x5,x2,x1 → 0; SRAI of 0x80000000 by 4 → 0xF8000000.
- ADDI x0,x0,7 → wb_valid=0; x0 reads 0.
- Illegal word 0x0000007F:
  - `err`=1, `done`=1, `retired` unchanged, PC still at that word.
  - A subsequent `start` clears `err` and refetches from PC 0.
- Edge cases:
  - `stop` held from mid-EXEC → halts after that instruction's WB.
  - `rst` pulsed during EXEC → all outputs return to reset values asynchronously.
  - IMEM_AW=2 with no ECALL → PC wraps 3→0 and execution continues.
